// File: rtl/e203_itcm_arb_pkg.sv
// e203_itcm_arb_pkg: shared source-ID type and default sizing for the ITCM arbiter.
package e203_itcm_arb_pkg;

  // Originator of an ITCM transaction; this is what the outstanding FIFO records.
  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  localparam int ITCM_AW           = 16;
  localparam int ITCM_DW           = 32;
  localparam int ITCM_OUTS_DEPTH   = 2;
  localparam int ITCM_STARVE_LIMIT = 4;

endpackage

// File: rtl/e203_itcm_arbiter_if.sv
// e203_itcm_arbiter_if: one command/response channel. The master issues commands
// and consumes responses; the slave accepts commands and returns responses.
// The IFU channel only uses cmd_addr of the command payload (fetches are reads).
interface e203_itcm_arbiter_if
  import e203_itcm_arb_pkg::*;
#(
  parameter int AW = ITCM_AW,
  parameter int DW = ITCM_DW
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/e203_itcm_arb_outs_fifo.sv
// e203_itcm_arb_outs_fifo: in-order record of which source owns each outstanding
// ITCM transaction, plus a running count of IFU-owned entries.
module e203_itcm_arb_outs_fifo
  import e203_itcm_arb_pkg::*;
#(
  parameter  int DEPTH = ITCM_OUTS_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  src_e          push_src_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output src_e          head_o,
  output logic [CW-1:0] ifu_cnt_o
);

  src_e          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ifu_cnt_q, ifu_cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign ifu_cnt_o = ifu_cnt_q;

  // Next-state for pointers and occupancy; push+pop together leaves counts unchanged.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d     = cnt_q + CW'(push_i) - CW'(pop_i);
    ifu_cnt_d = ifu_cnt_q + CW'(push_i && (push_src_i == SRC_IFU))
                          - CW'(pop_i && (head_o == SRC_IFU));
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ifu_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ifu_cnt_q <= ifu_cnt_d;
    end
  end

  // Source-ID storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; cnt_q alone decides which entries are live.
    if (push_i) mem_q[wr_ptr_q] <= push_src_i;
  end

endmodule

// File: rtl/e203_itcm_arbiter.sv
// e203_itcm_arbiter: shares the single ITCM command/response channel between the
// IFU (fetch, read-only) and the LSU. LSU has priority; the grant is locked while
// the target stalls; responses are routed in order using the outstanding FIFO.
// Optional feature macro: E203_ITCM_ARB_STARVE_EN (IFU anti-starvation counter).
module e203_itcm_arbiter
  import e203_itcm_arb_pkg::*;
#(
  parameter int AW           = ITCM_AW,
  parameter int DW           = ITCM_DW,
  parameter int OUTS_DEPTH   = ITCM_OUTS_DEPTH,
  parameter int STARVE_LIMIT = ITCM_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  e203_itcm_arbiter_if.slave          ifu,
  e203_itcm_arbiter_if.slave          lsu,
  e203_itcm_arbiter_if.master         tgt,
  output logic                        ifu_no_outs,
  output logic                        arb_proto_err
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  logic          grant_lock_q, grant_lock_d;
  src_e          grant_src_q,  grant_src_d;
  logic          proto_err_q,  proto_err_d;

  logic          outs_full, outs_empty;
  src_e          outs_head;
  logic [CW-1:0] ifu_cnt;

  src_e          sel_src;
  logic          sel_valid, ifu_force, cmd_hs, rsp_hs;
  logic [AW-1:0] sel_addr;
  logic          sel_read;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;

  // Fetches never write, so these IFU payload fields are intentionally ignored.
  logic unused_ifu_payload;
  assign unused_ifu_payload = ^{ifu.cmd_read, ifu.cmd_wdata, ifu.cmd_wmask};

`ifdef E203_ITCM_ARB_STARVE_EN
  logic [7:0] starve_q, starve_d;

  assign ifu_force = (starve_q == 8'(STARVE_LIMIT));

  // Count cycles IFU waits behind a granted LSU; an IFU handshake clears it.
  always_comb begin
    starve_d = starve_q;
    if (ifu.cmd_valid && ifu.cmd_ready) begin
      starve_d = '0;
    end else if (ifu.cmd_valid && lsu.cmd_valid && (sel_src == SRC_LSU) && !ifu_force) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign ifu_force = 1'b0;
`endif

  // Source selection and command mux; a locked grant overrides fresh arbitration.
  always_comb begin
    sel_src = SRC_IFU;
    if (grant_lock_q) begin
      sel_src = grant_src_q;
    end else if (lsu.cmd_valid && !(ifu.cmd_valid && ifu_force)) begin
      sel_src = SRC_LSU;
    end
    if (sel_src == SRC_LSU) begin
      sel_valid = lsu.cmd_valid;
      sel_addr  = lsu.cmd_addr;
      sel_read  = lsu.cmd_read;
      sel_wdata = lsu.cmd_wdata;
      sel_wmask = lsu.cmd_wmask;
    end else begin
      sel_valid = ifu.cmd_valid;
      sel_addr  = ifu.cmd_addr;
      sel_read  = 1'b1;
      sel_wdata = '0;
      sel_wmask = '0;
    end
  end

  assign tgt.cmd_valid = sel_valid & ~outs_full;
  assign tgt.cmd_addr  = sel_addr;
  assign tgt.cmd_read  = sel_read;
  assign tgt.cmd_wdata = sel_wdata;
  assign tgt.cmd_wmask = sel_wmask;
  assign ifu.cmd_ready = (sel_src == SRC_IFU) & sel_valid & tgt.cmd_ready & ~outs_full;
  assign lsu.cmd_ready = (sel_src == SRC_LSU) & sel_valid & tgt.cmd_ready & ~outs_full;
  assign cmd_hs        = tgt.cmd_valid & tgt.cmd_ready;

  // Response routing by FIFO head; with nothing outstanding the target is drained.
  always_comb begin
    ifu.rsp_valid = 1'b0;
    lsu.rsp_valid = 1'b0;
    tgt.rsp_ready = 1'b1;
    if (!outs_empty) begin
      if (outs_head == SRC_LSU) begin
        lsu.rsp_valid = tgt.rsp_valid;
        tgt.rsp_ready = lsu.rsp_ready;
      end else begin
        ifu.rsp_valid = tgt.rsp_valid;
        tgt.rsp_ready = ifu.rsp_ready;
      end
    end
  end

  assign ifu.rsp_rdata = tgt.rsp_rdata;
  assign ifu.rsp_err   = tgt.rsp_err;
  assign lsu.rsp_rdata = tgt.rsp_rdata;
  assign lsu.rsp_err   = tgt.rsp_err;
  assign rsp_hs        = tgt.rsp_valid & tgt.rsp_ready & ~outs_empty;

  e203_itcm_arb_outs_fifo #(.DEPTH(OUTS_DEPTH)) u_outs_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (cmd_hs),
    .push_src_i (sel_src),
    .pop_i      (rsp_hs),
    .full_o     (outs_full),
    .empty_o    (outs_empty),
    .head_o     (outs_head),
    .ifu_cnt_o  (ifu_cnt)
  );

  assign ifu_no_outs   = (ifu_cnt == '0);
  assign arb_proto_err = proto_err_q;

  // Grant lock while the target stalls; sticky error for unexpected responses.
  always_comb begin
    grant_lock_d = tgt.cmd_valid & ~tgt.cmd_ready;
    grant_src_d  = sel_src;
    proto_err_d  = proto_err_q | (tgt.rsp_valid & outs_empty);
  end

  // Grant and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_lock_q <= 1'b0;
      grant_src_q  <= SRC_IFU;
      proto_err_q  <= 1'b0;
    end else begin
      grant_lock_q <= grant_lock_d;
      grant_src_q  <= grant_src_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_e203_itcm_arbiter.sv
// tb_e203_itcm_arbiter: directed scenarios followed by randomized traffic, all
// checked against a transaction-level model (queue of outstanding owners).
module tb_e203_itcm_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef E203_ITCM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ifu_no_outs, arb_proto_err;

  always #5 clk = ~clk;

  e203_itcm_arbiter_if #(.AW(AW), .DW(DW)) ifu_bus ();
  e203_itcm_arbiter_if #(.AW(AW), .DW(DW)) lsu_bus ();
  e203_itcm_arbiter_if #(.AW(AW), .DW(DW)) tgt_bus ();

  e203_itcm_arbiter #(.AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu           (ifu_bus),
    .lsu           (lsu_bus),
    .tgt           (tgt_bus),
    .ifu_no_outs   (ifu_no_outs),
    .arb_proto_err (arb_proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owners of outstanding transactions (0 = IFU, 1 = LSU).
  bit m_q[$];
  int m_starve;
  bit m_lock, m_lock_src, m_proto;
  // Per-cycle expectations computed at the sampling point.
  bit x_full, x_any, x_src, x_src_valid, x_tv, x_ifu_rdy, x_lsu_rdy;
  bit x_ifu_rv, x_lsu_rv, x_rsp_rdy;
  bit hs_ifu, hs_lsu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge: predict every output and compare.
  task automatic settle();
    int ifu_in_q;
    @(negedge clk);
    x_full = (m_q.size() == DEPTH);
    x_any  = 1'b1;
    if (m_lock) x_src = m_lock_src;
    else if (lsu_bus.cmd_valid && !(ifu_bus.cmd_valid && STARVE_EN && m_starve >= LIMIT)) x_src = 1'b1;
    else if (ifu_bus.cmd_valid) x_src = 1'b0;
    else begin x_any = 1'b0; x_src = 1'b0; end
    x_src_valid = x_any && (x_src ? lsu_bus.cmd_valid : ifu_bus.cmd_valid);
    x_tv      = x_src_valid && !x_full;
    x_ifu_rdy = x_tv && !x_src && tgt_bus.cmd_ready;
    x_lsu_rdy = x_tv &&  x_src && tgt_bus.cmd_ready;
    x_ifu_rv  = 1'b0;
    x_lsu_rv  = 1'b0;
    x_rsp_rdy = 1'b1;
    if (m_q.size() != 0) begin
      if (m_q[0]) begin x_lsu_rv = tgt_bus.rsp_valid; x_rsp_rdy = lsu_bus.rsp_ready; end
      else        begin x_ifu_rv = tgt_bus.rsp_valid; x_rsp_rdy = ifu_bus.rsp_ready; end
    end
    ifu_in_q = 0;
    foreach (m_q[i]) if (!m_q[i]) ifu_in_q++;

    check("tgt_cmd_valid", tgt_bus.cmd_valid, x_tv);
    check("ifu_cmd_ready", ifu_bus.cmd_ready, x_ifu_rdy);
    check("lsu_cmd_ready", lsu_bus.cmd_ready, x_lsu_rdy);
    check("tgt_rsp_ready", tgt_bus.rsp_ready, x_rsp_rdy);
    check("ifu_rsp_valid", ifu_bus.rsp_valid, x_ifu_rv);
    check("lsu_rsp_valid", lsu_bus.rsp_valid, x_lsu_rv);
    check("ifu_no_outs",   ifu_no_outs, ifu_in_q == 0);
    check("arb_proto_err", arb_proto_err, m_proto);
    if (x_tv) begin
      check("tgt_cmd_addr",  tgt_bus.cmd_addr,  x_src ? lsu_bus.cmd_addr  : ifu_bus.cmd_addr);
      check("tgt_cmd_read",  tgt_bus.cmd_read,  x_src ? lsu_bus.cmd_read  : 1'b1);
      check("tgt_cmd_wdata", tgt_bus.cmd_wdata, x_src ? 64'(lsu_bus.cmd_wdata) : 64'(0));
      check("tgt_cmd_wmask", tgt_bus.cmd_wmask, x_src ? 64'(lsu_bus.cmd_wmask) : 64'(0));
    end
    if (x_ifu_rv) begin
      check("ifu_rsp_rdata", ifu_bus.rsp_rdata, tgt_bus.rsp_rdata);
      check("ifu_rsp_err",   ifu_bus.rsp_err,   tgt_bus.rsp_err);
    end
    if (x_lsu_rv) begin
      check("lsu_rsp_rdata", lsu_bus.rsp_rdata, tgt_bus.rsp_rdata);
      check("lsu_rsp_err",   lsu_bus.rsp_err,   tgt_bus.rsp_err);
    end
  endtask

  // Advance the model by one clock using the predictions made in settle().
  task automatic tick();
    bit emp;
    emp    = (m_q.size() == 0);
    hs_ifu = x_tv && tgt_bus.cmd_ready && !x_src;
    hs_lsu = x_tv && tgt_bus.cmd_ready &&  x_src;
    if (tgt_bus.rsp_valid && x_rsp_rdy && !emp) void'(m_q.pop_front());
    if (hs_ifu || hs_lsu) m_q.push_back(x_src);
    if (tgt_bus.rsp_valid && emp) m_proto = 1'b1;
    m_lock     = x_tv && !tgt_bus.cmd_ready;
    m_lock_src = x_src;
    if (STARVE_EN) begin
      if (hs_ifu) m_starve = 0;
      else if (ifu_bus.cmd_valid && lsu_bus.cmd_valid && x_any && x_src && m_starve < LIMIT) m_starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_starve = 0;
    m_lock = 1'b0; m_lock_src = 1'b0; m_proto = 1'b0;
    hs_ifu = 1'b0; hs_lsu = 1'b0;
  endtask

  task automatic idle_inputs();
    ifu_bus.cmd_valid = 1'b0;
    lsu_bus.cmd_valid = 1'b0;
    tgt_bus.rsp_valid = 1'b0;
  endtask

  // Return a response for everything outstanding, bounded to a few cycles.
  task automatic drain();
    idle_inputs();
    ifu_bus.rsp_ready = 1'b1;
    lsu_bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && m_q.size() != 0; i++) begin
      tgt_bus.rsp_valid = 1'b1;
      tgt_bus.rsp_rdata = $urandom;
      tgt_bus.rsp_err   = 1'b0;
      cycle();
    end
    tgt_bus.rsp_valid = 1'b0;
    check("drain_no_outs", ifu_no_outs, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifu_bus.cmd_valid = 1'b0; ifu_bus.cmd_addr = '0; ifu_bus.cmd_read = 1'b1;
    ifu_bus.cmd_wdata = '0;   ifu_bus.cmd_wmask = '0; ifu_bus.rsp_ready = 1'b1;
    lsu_bus.cmd_valid = 1'b0; lsu_bus.cmd_addr = '0; lsu_bus.cmd_read = 1'b1;
    lsu_bus.cmd_wdata = '0;   lsu_bus.cmd_wmask = '0; lsu_bus.rsp_ready = 1'b1;
    tgt_bus.cmd_ready = 1'b1; tgt_bus.rsp_valid = 1'b0;
    tgt_bus.rsp_rdata = '0;   tgt_bus.rsp_err = 1'b0;
    reset_dut();

    // Idle after reset: only tgt_rsp_ready is asserted.
    settle();
    check("rst_tgt_cmd_valid", tgt_bus.cmd_valid, 1'b0);
    check("rst_ifu_cmd_ready", ifu_bus.cmd_ready, 1'b0);
    check("rst_lsu_cmd_ready", lsu_bus.cmd_ready, 1'b0);
    check("rst_ifu_rsp_valid", ifu_bus.rsp_valid, 1'b0);
    check("rst_lsu_rsp_valid", lsu_bus.rsp_valid, 1'b0);
    check("rst_tgt_rsp_ready", tgt_bus.rsp_ready, 1'b1);
    check("rst_ifu_no_outs",   ifu_no_outs, 1'b1);
    check("rst_proto_err",     arb_proto_err, 1'b0);
    tick();

    // Outstanding limit: two fetches fill the FIFO, a pop frees a slot only next cycle.
    ifu_bus.cmd_valid = 1'b1; ifu_bus.cmd_addr = 16'h0010; cycle();
    ifu_bus.cmd_addr = 16'h0014; cycle();
    ifu_bus.cmd_addr = 16'h0018;
    settle();
    check("full_ifu_cmd_ready", ifu_bus.cmd_ready, 1'b0);
    check("full_tgt_cmd_valid", tgt_bus.cmd_valid, 1'b0);
    tick();
    tgt_bus.rsp_valid = 1'b1; tgt_bus.rsp_rdata = 32'h1111_0000;
    settle();
    check("full_pop_no_bypass", ifu_bus.cmd_ready, 1'b0);
    check("full_pop_rsp_valid", ifu_bus.rsp_valid, 1'b1);
    tick();
    tgt_bus.rsp_valid = 1'b0;
    settle();
    check("after_pop_ifu_ready", ifu_bus.cmd_ready, 1'b1);
    tick();
    drain();

    // Interleaved IFU then LSU read, responses routed in order.
    ifu_bus.cmd_valid = 1'b1; ifu_bus.cmd_addr = 16'h0100; cycle();
    ifu_bus.cmd_valid = 1'b0;
    lsu_bus.cmd_valid = 1'b1; lsu_bus.cmd_addr = 16'h0200; lsu_bus.cmd_read = 1'b1; cycle();
    lsu_bus.cmd_valid = 1'b0;
    settle();
    check("ilv_ifu_outs", ifu_no_outs, 1'b0);
    tick();
    tgt_bus.rsp_valid = 1'b1; tgt_bus.rsp_rdata = 32'hAAAA_0001;
    settle();
    check("ilv_rsp1_ifu_valid", ifu_bus.rsp_valid, 1'b1);
    check("ilv_rsp1_ifu_rdata", ifu_bus.rsp_rdata, 32'hAAAA_0001);
    check("ilv_rsp1_lsu_valid", lsu_bus.rsp_valid, 1'b0);
    tick();
    tgt_bus.rsp_rdata = 32'h5555_0002;
    settle();
    check("ilv_no_outs_back", ifu_no_outs, 1'b1);
    check("ilv_rsp2_lsu_valid", lsu_bus.rsp_valid, 1'b1);
    check("ilv_rsp2_lsu_rdata", lsu_bus.rsp_rdata, 32'h5555_0002);
    check("ilv_rsp2_ifu_valid", ifu_bus.rsp_valid, 1'b0);
    tick();
    tgt_bus.rsp_valid = 1'b0;

    // Stray response with nothing outstanding: drained, sticky error until reset.
    tgt_bus.rsp_valid = 1'b1;
    settle();
    check("stray_tgt_rsp_ready", tgt_bus.rsp_ready, 1'b1);
    check("stray_ifu_rsp_valid", ifu_bus.rsp_valid, 1'b0);
    check("stray_lsu_rsp_valid", lsu_bus.rsp_valid, 1'b0);
    tick();
    tgt_bus.rsp_valid = 1'b0;
    settle(); check("stray_err_set", arb_proto_err, 1'b1); tick();
    settle(); check("stray_err_sticky", arb_proto_err, 1'b1); tick();
    reset_dut();
    settle(); check("stray_err_cleared", arb_proto_err, 1'b0); tick();

    // Target backpressure: the LSU write stays muxed while IFU waits.
    tgt_bus.cmd_ready = 1'b0;
    lsu_bus.cmd_valid = 1'b1; lsu_bus.cmd_addr = 16'h0040; lsu_bus.cmd_read = 1'b0;
    lsu_bus.cmd_wdata = 32'hDEAD_BEEF; lsu_bus.cmd_wmask = 4'hF;
    cycle();
    ifu_bus.cmd_valid = 1'b1; ifu_bus.cmd_addr = 16'h0300;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_addr_stable",  tgt_bus.cmd_addr, 16'h0040);
      check("bp_wdata_stable", tgt_bus.cmd_wdata, 32'hDEAD_BEEF);
      check("bp_ifu_ready",    ifu_bus.cmd_ready, 1'b0);
      tick();
    end
    tgt_bus.cmd_ready = 1'b1;
    settle();
    check("bp_lsu_handshake", lsu_bus.cmd_ready, 1'b1);
    check("bp_ifu_ready_end", ifu_bus.cmd_ready, 1'b0);
    check("bp_addr_final",    tgt_bus.cmd_addr, 16'h0040);
    tick();
    drain();

    // Reset with two transactions outstanding (and a non-zero starvation count).
    ifu_bus.cmd_valid = 1'b1; ifu_bus.cmd_addr = 16'h0500; cycle();
    ifu_bus.cmd_valid = 1'b0;
    lsu_bus.cmd_valid = 1'b1; lsu_bus.cmd_addr = 16'h0600; lsu_bus.cmd_read = 1'b1; cycle();
    ifu_bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    settle();
    check("mid_full_lsu_ready", lsu_bus.cmd_ready, 1'b0);
    check("mid_ifu_outs",       ifu_no_outs, 1'b0);
    tick();
    reset_dut();
    settle();
    check("mid_rst_no_outs",   ifu_no_outs, 1'b1);
    check("mid_rst_rsp_ready", tgt_bus.rsp_ready, 1'b1);
    check("mid_rst_lsu_ready", lsu_bus.cmd_ready, 1'b1);

    // Both requesting every cycle: grant pattern from a cleared starvation count.
    ifu_bus.rsp_ready = 1'b1; lsu_bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) settle();
      check("starve_grant_lsu", lsu_bus.cmd_ready, (STARVE_EN && (i % 5 == 4)) ? 1'b0 : 1'b1);
      check("starve_grant_ifu", ifu_bus.cmd_ready, (STARVE_EN && (i % 5 == 4)) ? 1'b1 : 1'b0);
      tick();
      ifu_bus.cmd_addr  = 16'h0800 + 16'(4 * i);
      lsu_bus.cmd_addr  = 16'h0900 + 16'(4 * i);
      tgt_bus.rsp_valid = (m_q.size() != 0);
      tgt_bus.rsp_rdata = $urandom;
    end
    drain();

    // Randomized traffic; requesters hold their command until it is accepted.
    hs_ifu = 1'b1; hs_lsu = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!ifu_bus.cmd_valid || hs_ifu) begin
        ifu_bus.cmd_valid = ($urandom_range(0, 1) == 1);
        ifu_bus.cmd_addr  = AW'($urandom);
      end
      if (!lsu_bus.cmd_valid || hs_lsu) begin
        lsu_bus.cmd_valid = ($urandom_range(0, 1) == 1);
        lsu_bus.cmd_addr  = AW'($urandom);
        lsu_bus.cmd_read  = ($urandom_range(0, 1) == 1);
        lsu_bus.cmd_wdata = $urandom;
        lsu_bus.cmd_wmask = MW'($urandom);
      end
      tgt_bus.cmd_ready = ($urandom_range(0, 3) != 0);
      tgt_bus.rsp_valid = (m_q.size() != 0) && ($urandom_range(0, 3) != 0);
      tgt_bus.rsp_rdata = $urandom;
      tgt_bus.rsp_err   = ($urandom_range(0, 7) == 0);
      ifu_bus.rsp_ready = ($urandom_range(0, 3) != 0);
      lsu_bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    tgt_bus.cmd_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
